// File: rtl/neuron_layer_mac_serial.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// neuron_layer_mac_serial
//
// Dense-layer evaluator. It takes one operation (an input vector, a weight
// matrix, per-neuron biases and an activation mode) and then produces
// NUM_NEURONS results, one at a time. LANES products are formed per MAC
// cycle. Each result is bias-aligned, activated, requantized and saturated,
// and then streamed out over a valid/ready handshake.
//
// Optional feature:
//   NEURON_LAYER_SAT_CNT_EN - when defined, adds the sat_count output, a
//   16-bit saturating count of results that were clipped. Only reset clears
//   it.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   in_valid   operation request
//   in_ready   block is idle and can accept an operation
//   act_mode   0 none, 1 ReLU, 2 leaky ReLU (x>>>3), 3 none; captured on accept
//   x_flat     input vector, element i at [i*X_W +: X_W]
//   w_flat     weights, neuron n element i at index n*NUM_INPUTS+i
//   b_flat     biases, neuron n at [n*B_W +: B_W]
//   out_valid  out_data/out_idx/out_last are valid
//   out_ready  downstream accepts the current result
//   out_data   signed result (OUT_FRAC fractional bits)
//   out_idx    neuron index of out_data
//   out_last   high with the result of neuron NUM_NEURONS-1
//   busy       block is not idle
//   sat_count  clipped-result counter (NEURON_LAYER_SAT_CNT_EN only)
//
// state | meaning
// IDLE  | waiting for an operation; in_ready high
// MAC   | K product issue cycles plus one drain cycle for the product register
// FIN   | bias, activation, requantize and saturate; register the result
// OUT   | result presented; wait for out_ready
// -----------------------------------------------------------------------------
module neuron_layer_mac_serial #(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_NEURONS = 4,
  parameter int LANES       = 2,
  parameter int X_W         = 8,
  parameter int W_W         = 8,
  parameter int B_W         = 32,
  parameter int OUT_W       = 16,
  parameter int X_FRAC      = 4,
  parameter int W_FRAC      = 4,
  parameter int B_FRAC      = 8,
  parameter int OUT_FRAC    = 8,
  parameter int GUARD_BITS  = 2
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [1:0]                                      act_mode,
  input  logic [NUM_INPUTS*X_W-1:0]                       x_flat,
  input  logic [NUM_NEURONS*NUM_INPUTS*W_W-1:0]           w_flat,
  input  logic [NUM_NEURONS*B_W-1:0]                      b_flat,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic signed [OUT_W-1:0]                         out_data,
  output logic [((NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1)-1:0] out_idx,
  output logic                                            out_last,
  output logic                                            busy
`ifdef NEURON_LAYER_SAT_CNT_EN
  ,
  output logic [15:0]                                     sat_count
`endif
);

  localparam int K      = NUM_INPUTS / LANES;
  localparam int IDX_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int CNT_W  = $clog2(K + 1);
  localparam int P_FRAC = X_FRAC + W_FRAC;
  localparam int PROD_W = X_W + W_W;
  localparam int ACC_A  = X_W + W_W + $clog2(NUM_INPUTS);
  localparam int B_SHL  = (B_FRAC < P_FRAC) ? P_FRAC - B_FRAC : 0;
  localparam int B_SHR  = (B_FRAC > P_FRAC) ? B_FRAC - P_FRAC : 0;
  localparam int ACC_B  = B_W + B_SHL;
  localparam int ACC_W  = ((ACC_A > ACC_B) ? ACC_A : ACC_B) + GUARD_BITS + 1;
  localparam int RQ_SHR = (OUT_FRAC < P_FRAC) ? P_FRAC - OUT_FRAC : 0;
  localparam int RQ_SHL = (OUT_FRAC > P_FRAC) ? OUT_FRAC - P_FRAC : 0;
  // One extra bit keeps the rounding add from wrapping.
  localparam int RQ_W   = ACC_W + RQ_SHL + 1;
  localparam int RND_VAL = (RQ_SHR > 0) ? (1 << ((RQ_SHR > 0) ? RQ_SHR - 1 : 0)) : 0;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(K);
  localparam logic signed [RQ_W-1:0] SAT_MAX =
    $signed({{(RQ_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [RQ_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_FIN  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [NUM_INPUTS*X_W-1:0]             x_q;
  logic [NUM_NEURONS*NUM_INPUTS*W_W-1:0] w_q;
  logic [NUM_NEURONS*B_W-1:0]            b_q;
  logic [1:0]                            mode_q;
  logic signed [ACC_W-1:0]               acc;
  logic signed [ACC_W-1:0]               prod_q;
  logic [CNT_W-1:0]                      cnt;
  logic [IDX_W-1:0]                      n_idx;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid) state_nxt = S_MAC;
      S_MAC:  if (cnt == CNT_END) state_nxt = S_FIN;
      S_FIN:  state_nxt = S_OUT;
      S_OUT:  if (out_ready) state_nxt = (n_idx == LAST_IDX) ? S_IDLE : S_MAC;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_IDLE);
    busy     = (state != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Lane multipliers. Once every product is issued (cnt == K), the slice
  // select falls back to chunk 0. That product goes unused.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]         issue_j;
  logic signed [PROD_W-1:0] lane_prod [LANES];
  logic signed [ACC_W-1:0]  lane_sum;

  assign issue_j = (cnt < CNT_END) ? cnt : '0;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [X_W-1:0] x_e;
    logic signed [W_W-1:0] w_e;
    assign x_e = x_q[(int'(issue_j) * LANES + l) * X_W +: X_W];
    assign w_e = w_q[(int'(n_idx) * NUM_INPUTS + int'(issue_j) * LANES + l) * W_W +: W_W];
    assign lane_prod[l] = PROD_W'(x_e) * PROD_W'(w_e);
  end

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) lane_sum = lane_sum + ACC_W'(lane_prod[l]);
  end

  // ---------------------------------------------------------------------------
  // Finish path: bias alignment, activation, requantize, saturate
  // ---------------------------------------------------------------------------
  logic signed [B_W-1:0]   bias_sel;
  logic signed [ACC_W-1:0] bias_al;
  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] activated;
  logic signed [RQ_W-1:0]  rq_rnd;
  logic signed [RQ_W-1:0]  rq_val;
  logic signed [OUT_W-1:0] fin_data;

  always_comb begin
    bias_sel = b_q[int'(n_idx) * B_W +: B_W];
    // Only one of B_SHL and B_SHR is ever nonzero.
    bias_al  = (ACC_W'(bias_sel) <<< B_SHL) >>> B_SHR;
    biased   = acc + bias_al;
    case (mode_q)
      2'd1:    activated = biased[ACC_W-1] ? '0 : biased;
      2'd2:    activated = biased[ACC_W-1] ? (biased >>> 3) : biased;
      default: activated = biased;
    endcase
    rq_rnd = RQ_W'(activated) + RQ_W'(RND_VAL);
    rq_val = (rq_rnd >>> RQ_SHR) <<< RQ_SHL;
    if (rq_val > SAT_MAX)      fin_data = SAT_MAX[OUT_W-1:0];
    else if (rq_val < SAT_MIN) fin_data = SAT_MIN[OUT_W-1:0];
    else                       fin_data = rq_val[OUT_W-1:0];
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q       <= '0;
      w_q       <= '0;
      b_q       <= '0;
      mode_q    <= '0;
      acc       <= '0;
      prod_q    <= '0;
      cnt       <= '0;
      n_idx     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          acc   <= '0;
          cnt   <= '0;
          n_idx <= '0;
          if (in_valid) begin
            x_q    <= x_flat;
            w_q    <= w_flat;
            b_q    <= b_flat;
            mode_q <= act_mode;
          end
        end
        S_MAC: begin
          // prod_q holds the previous cycle's lane sum. It is folded into acc
          // one cycle later, so the cnt == K cycle only drains the last sum.
          prod_q <= lane_sum;
          if (cnt != '0) acc <= acc + prod_q;
          if (cnt != CNT_END) cnt <= cnt + 1'b1;
        end
        S_FIN: begin
          out_data  <= fin_data;
          out_idx   <= n_idx;
          out_last  <= (n_idx == LAST_IDX);
          out_valid <= 1'b1;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            n_idx     <= (n_idx == LAST_IDX) ? '0 : n_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef NEURON_LAYER_SAT_CNT_EN
  logic fin_clip;

  assign fin_clip = (rq_val > SAT_MAX) || (rq_val < SAT_MIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (state == S_FIN && fin_clip && sat_count != 16'hFFFF) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_neuron_layer_mac_serial.sv
`timescale 1ns/1ps
module tb_neuron_layer_mac_serial;

  localparam int NI = 8;
  localparam int NN = 4;
  localparam int XW = 8;
  localparam int WW = 8;
  localparam int BW = 32;
  localparam int OW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          act_mode;
  logic [NI*XW-1:0]    x_flat;
  logic [NN*NI*WW-1:0] w_flat;
  logic [NN*BW-1:0]    b_flat;
  logic                out_valid;
  logic                out_ready;
  logic [OW-1:0]       out_data;
  logic [1:0]          out_idx;
  logic                out_last;
  logic                busy;

  logic                in_valid_b;
  logic                in_ready_b;
  logic [NI*XW-1:0]    x_flat_b;
  logic [NN*NI*WW-1:0] w_flat_b;
  logic [NN*BW-1:0]    b_flat_b;
  logic                out_valid_b;
  logic [OW-1:0]       out_data_b;
  logic [1:0]          out_idx_b;
  logic                out_last_b;
  logic                busy_b;
`ifdef NEURON_LAYER_SAT_CNT_EN
  logic [15:0]         sat_count;
  logic [15:0]         sat_count_b;
`endif

  neuron_layer_mac_serial u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .act_mode  (act_mode),
    .x_flat    (x_flat),
    .w_flat    (w_flat),
    .b_flat    (b_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
`ifdef NEURON_LAYER_SAT_CNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  // Same block with a bias format finer than the product format.
  neuron_layer_mac_serial #(.B_FRAC(10)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .act_mode  (2'd0),
    .x_flat    (x_flat_b),
    .w_flat    (w_flat_b),
    .b_flat    (b_flat_b),
    .out_valid (out_valid_b),
    .out_ready (1'b1),
    .out_data  (out_data_b),
    .out_idx   (out_idx_b),
    .out_last  (out_last_b),
    .busy      (busy_b)
`ifdef NEURON_LAYER_SAT_CNT_EN
    ,
    .sat_count (sat_count_b)
`endif
  );

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  exp_t sb_q[$];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   acc_cyc = 0;
  int   hs_cyc = 0;
  int   nb_cnt = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for the DUT (t=%0t)", name, $time);
  endtask

  // Main monitor: latency/spacing on each rising out_valid, scoreboard compare on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (out_idx == 2'd0) check("latency", cyc - acc_cyc, 6);
        else                 check("spacing", cyc - hs_cyc, 6);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got data 0x%0h idx %0d, expected no output", out_data, out_idx);
        end else begin
          e = sb_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_idx_last", {out_idx, out_last}, {e.idx, e.last});
        end
        hs_cyc = cyc + 1;
      end
      prev_v = out_valid;
    end
  end

  // Monitor for the B_FRAC=10 instance: bias 0x600 aligns to 0x180.
  always @(negedge clk) begin
    if (!rst && out_valid_b) begin
      check("bfrac_data", out_data_b, 16'h0180);
      check("bfrac_idx", out_idx_b, nb_cnt);
      nb_cnt++;
    end
  end

  task automatic fill_uniform(input logic [7:0] xv, input logic [7:0] wv,
                              input logic [31:0] b0, input logic [31:0] bstep);
    for (int i = 0; i < NI; i++) x_flat[i*XW +: XW] = xv;
    for (int i = 0; i < NN*NI; i++) w_flat[i*WW +: WW] = wv;
    for (int n = 0; n < NN; n++) b_flat[n*BW +: BW] = b0 + bstep * n;
  endtask

  // x[i] = i, w[n][i] = i + n, no bias -> result raw = sum(i*(i+n)) = 140 + 28n.
  task automatic fill_ramp();
    for (int i = 0; i < NI; i++) x_flat[i*XW +: XW] = 8'(i);
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < NI; i++) w_flat[(n*NI+i)*WW +: WW] = 8'(i + n);
    b_flat = '0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (!(in_ready === 1'b1 && sb_q.size() == 0) && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 400) begin
      timeout_fail(name);
      sb_q.delete();
    end
  endtask

  task automatic issue(input logic [1:0] mode, input logic [15:0] e0, input logic [15:0] e1,
                       input logic [15:0] e2, input logic [15:0] e3, input int n_push);
    logic [15:0] ev [4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    wait_idle("pre_accept");
    act_mode = mode;
    for (int n = 0; n < n_push; n++)
      sb_q.push_back('{data: ev[n], idx: 2'(n), last: (n == NN-1)});
    in_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    // Inputs are registered on accept, so scrambling them now must not matter.
    x_flat   = ~x_flat;
    w_flat   = ~w_flat;
    b_flat   = ~b_flat;
    act_mode = ~mode;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data, 0);
    check({tag, "_out_idx"},   out_idx, 0);
    check({tag, "_out_last"},  out_last, 0);
    check({tag, "_busy"},      busy, 0);
`ifdef NEURON_LAYER_SAT_CNT_EN
    check({tag, "_sat_count"}, sat_count, 0);
`endif
  endtask

  initial begin
    logic [15:0] hold_d;
    logic [1:0]  hold_i;
    int          t;

    rst        = 1'b1;
    in_valid   = 1'b0;
    act_mode   = 2'd0;
    x_flat     = '0;
    w_flat     = '0;
    b_flat     = '0;
    out_ready  = 1'b1;
    in_valid_b = 1'b0;
    x_flat_b   = '0;
    w_flat_b   = {(NN*NI){8'h10}};
    b_flat_b   = {NN{32'h0000_0600}};

    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // 1: plain dot product, 8 x (1.0 * 1.0) = 8.0
    fill_uniform(8'h10, 8'h10, 32'h0, 32'h0);
    issue(2'd0, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 4);

    // 2: negative sum through each activation
    fill_uniform(8'h10, 8'hF0, 32'h0, 32'h0);
    issue(2'd1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4);
    fill_uniform(8'h10, 8'hF0, 32'h0, 32'h0);
    issue(2'd2, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 4);
    fill_uniform(8'h10, 8'hF0, 32'h0, 32'h0);
    issue(2'd3, 16'hF800, 16'hF800, 16'hF800, 16'hF800, 4);

    // 3: saturation both ways
    fill_uniform(8'h7F, 8'h7F, 32'h0, 32'h0);
    issue(2'd0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 4);
    fill_uniform(8'h80, 8'h7F, 32'h0, 32'h0);
    issue(2'd0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 4);
    wait_idle("sat_drain");
`ifdef NEURON_LAYER_SAT_CNT_EN
    check("sat_count", sat_count, 16'd8);
`endif

    // Element/neuron indexing with distinct values
    fill_ramp();
    issue(2'd0, 16'h008C, 16'h00A8, 16'h00C4, 16'h00E0, 4);

    // 4: bias only, plus the B_FRAC=10 instance
    fill_uniform(8'h00, 8'h10, 32'h180, 32'h1);
    issue(2'd0, 16'h0180, 16'h0181, 16'h0182, 16'h0183, 4);
    in_valid_b = 1'b1;
    @(posedge clk); #1;
    in_valid_b = 1'b0;

    // 5: backpressure at neuron 1
    fill_uniform(8'h10, 8'h10, 32'h0, 32'h0);
    issue(2'd0, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 4);
    t = 0;
    while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) timeout_fail("bp_first_valid");
    @(posedge clk); #1;
    out_ready = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) timeout_fail("bp_second_valid");
    hold_d = out_data;
    hold_i = out_idx;
    check("bp_idx", hold_i, 1);
    x_flat   = {NI{8'h33}};
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_data_hold", out_data, hold_d);
      check("bp_idx_hold", out_idx, hold_i);
      check("bp_valid_hold", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    wait_idle("bp_drain");
    repeat (20) @(posedge clk);
    #1;
    check("bp_no_extra_op", busy, 0);

    // 6: reset during neuron 2's MAC; only neurons 0 and 1 may come out
    fill_uniform(8'h10, 8'h10, 32'h0, 32'h0);
    issue(2'd0, 16'h0800, 16'h0800, 16'h0, 16'h0, 2);
    repeat (16) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    check("midrst_sb_drained", sb_q.size(), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fill_uniform(8'h10, 8'h10, 32'h0, 32'h0);
    issue(2'd0, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 4);

    wait_idle("final_drain");
    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);
    check("bfrac_count", nb_cnt, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
